memoire_arbiter: RTL and testbench

Two-master arbiter placed in front of the single-port on-chip memory (16384 × 32-bit words, byte-enabled, one-cycle read latency). It shares the memory's single port between a CPU-side master (port 0) and a DMA-side master (port 1). Arbitration is round-robin, with an optional bounded lock for read-modify-write sequences. Reads are fully pipelined: one transaction is accepted per cycle, and each read returns its data exactly one cycle after acceptance.

---
 rtl/memoire_arbiter_pkg.sv | 13 +
 rtl/memoire_arbiter_if.sv | 28 ++
 rtl/memoire_arbiter_rr_pick.sv | 33 +++
 rtl/memoire_arbiter.sv | 136 +++++++++++++
 tb/tb_memoire_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memoire_arbiter_pkg.sv
// Shared types and constants for the two-master on-chip memory arbiter.
package memoire_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef logic port_idx_t;

  localparam int LOCK_CNT_W = 8;

endpackage

// File: rtl/memoire_arbiter_if.sv
// Master-side bus bundle of the memory arbiter: requests flow from the
// master, waitrequest and read responses flow back from the arbiter.
interface memoire_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                lock;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/memoire_arbiter_rr_pick.sv
// Combinational two-way round-robin picker: among eligible requesters,
// the one that did not win last time takes the grant.
module memoire_rr_pick
  import memoire_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  last,
  input  logic [1:0] eligible,
  output logic [1:0] gnt,
  output port_idx_t  gnt_idx
);

  logic [1:0] cand;

  assign cand = req & eligible;

  // Resolve contention against the last winner, otherwise grant the lone candidate.
  always_comb begin
    gnt     = 2'b00;
    gnt_idx = 1'b0;
    if (cand == 2'b11) begin
      gnt_idx = ~last;
      gnt     = last ? 2'b01 : 2'b10;
    end else if (cand[0]) begin
      gnt_idx = 1'b0;
      gnt     = 2'b01;
    end else if (cand[1]) begin
      gnt_idx = 1'b1;
      gnt     = 2'b10;
    end
  end

endmodule

// File: rtl/memoire_arbiter.sv
// Shares the single port of the on-chip RAM between a CPU master (m0) and
// a DMA master (m1): round-robin arbitration, a bounded lock for
// read-modify-write, and a one-cycle registered read tag.
module memoire_arbiter
  import memoire_arb_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                freeze,
  memoire_arbiter_if.slave    m0,
  memoire_arbiter_if.slave    m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  arb_state_e            state;
  port_idx_t             owner;
  port_idx_t             last;
  port_idx_t             rd_port;
  port_idx_t             gnt_idx;
  logic [LOCK_CNT_W-1:0] lock_cnt;
  logic                  rd_pend;
  logic [1:0]            req;
  logic [1:0]            eligible;
  logic [1:0]            gnt;
  logic                  gnt_any;
  logic                  gnt_read;
  logic                  gnt_lock;

  assign req     = {m1.read | m1.write, m0.read | m0.write};
  assign gnt_any = |gnt;

  // Freeze blocks everyone; a lock narrows eligibility to the owner.
  always_comb begin
    eligible = 2'b00;
    if (!freeze) begin
      if (state == LOCKED) begin
        eligible = owner ? 2'b10 : 2'b01;
      end else begin
        eligible = 2'b11;
      end
    end
  end

  memoire_rr_pick u_pick (
    .req      (req),
    .last     (last),
    .eligible (eligible),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  // Steer the granted master onto the RAM port.
  always_comb begin
    if (gnt_idx) begin
      mem_address    = m1.address;
      mem_byteenable = m1.byteenable;
      mem_writedata  = m1.writedata;
      mem_write      = gnt_any & m1.write;
      gnt_read       = gnt_any & m1.read;
      gnt_lock       = m1.lock;
    end else begin
      mem_address    = m0.address;
      mem_byteenable = m0.byteenable;
      mem_writedata  = m0.writedata;
      mem_write      = gnt_any & m0.write;
      gnt_read       = gnt_any & m0.read;
      gnt_lock       = m0.lock;
    end
  end

  assign mem_chipselect = gnt_any;
  assign mem_clken      = 1'b1;

  assign m0.waitrequest = freeze | ((state == LOCKED) & owner)  | (req[0] & ~gnt[0]);
  assign m1.waitrequest = freeze | ((state == LOCKED) & ~owner) | (req[1] & ~gnt[1]);

  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = rd_pend & (rd_port == 1'b0);
  assign m1.readdatavalid = rd_pend & (rd_port == 1'b1);

  // Arbitration state: round-robin pointer, lock entry, countdown and release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ARB;
      owner    <= 1'b0;
      last     <= 1'b1;
      lock_cnt <= '0;
    end else begin
      if (gnt_any) begin
        last <= gnt_idx;
      end
      case (state)
        ARB: begin
          if (gnt_any && gnt_lock) begin
            state    <= LOCKED;
            owner    <= gnt_idx;
            lock_cnt <= LOCK_CNT_W'(LOCK_MAX - 1);
          end
        end
        LOCKED: begin
          if ((gnt_any && !gnt_lock) || (lock_cnt == '0)) begin
            state    <= ARB;
            last     <= owner;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // Tag each granted read so its data is routed back one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend <= 1'b0;
      rd_port <= 1'b0;
    end else begin
      rd_pend <= gnt_read;
      rd_port <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_memoire_arbiter.sv
// Self-checking bench for memoire_arbiter with a behavioural RAM and a
// transaction-level reference model of grants, locks and read returns.
module tb_memoire_arbiter;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 32;
  localparam int LOCK_MAX = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic freeze;

  memoire_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  memoire_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       ram_q;

  memoire_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .freeze         (freeze),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (ram_q)
  );

  always #5 clk = ~clk;

  logic [31:0]       ram [0:16383];
  logic              pre_en = 1'b0;
  logic [ADDR_W-1:0] pre_addr;
  logic [31:0]       pre_data;

  // Behavioural RAM: byte-enabled writes, one-cycle read latency, backdoor preload.
  always @(posedge clk) begin
    if (pre_en) begin
      ram[pre_addr] <= pre_data;
    end else if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end

  typedef struct packed {
    logic              wr0;
    logic              wr1;
    logic              cs;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic              rdv0;
    logic              rdv1;
    logic [31:0]       rd0;
    logic [31:0]       rd1;
  } view_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_last;
  bit          m_locked;
  int          m_owner;
  int          m_remaining;
  bit          m_pend;
  int          m_pend_port;
  logic [31:0] m_pend_data;
  logic [31:0] ref_mem [0:63];

  function automatic bit p_rd(int p);  return p != 0 ? m1_if.read  : m0_if.read;  endfunction
  function automatic bit p_wr(int p);  return p != 0 ? m1_if.write : m0_if.write; endfunction
  function automatic bit p_lk(int p);  return p != 0 ? m1_if.lock  : m0_if.lock;  endfunction
  function automatic int p_addr(int p); return int'(p != 0 ? m1_if.address : m0_if.address); endfunction

  function automatic void model_reset();
    m_last = 1; m_locked = 0; m_owner = 0; m_remaining = 0; m_pend = 0;
  endfunction

  function automatic logic [1:0] model_grant();
    bit r0 = p_rd(0) | p_wr(0);
    bit r1 = p_rd(1) | p_wr(1);
    if (freeze) return 2'b00;
    if (m_locked) return (m_owner == 0) ? {1'b0, r0} : {r1, 1'b0};
    if (r0 && r1) return (m_last == 0) ? 2'b10 : 2'b01;
    return {r1, r0};
  endfunction

  function automatic view_t model_expect();
    view_t v;
    logic [1:0] g = model_grant();
    bit r0 = p_rd(0) | p_wr(0);
    bit r1 = p_rd(1) | p_wr(1);
    int gi = g[1] ? 1 : 0;
    v.wr0  = freeze || (m_locked && m_owner != 0) || (r0 && !g[0]);
    v.wr1  = freeze || (m_locked && m_owner != 1) || (r1 && !g[1]);
    v.cs   = |g;
    v.wr   = (|g) ? p_wr(gi) : 1'b0;
    v.addr = (|g) ? ADDR_W'(p_addr(gi)) : '0;
    v.rdv0 = m_pend && m_pend_port == 0;
    v.rdv1 = m_pend && m_pend_port == 1;
    v.rd0  = v.rdv0 ? m_pend_data : 32'h0;
    v.rd1  = v.rdv1 ? m_pend_data : 32'h0;
    return v;
  endfunction

  function automatic void model_commit();
    logic [1:0] g = model_grant();
    bit was_locked = m_locked;
    bit lk = 0;
    int gi = g[1] ? 1 : 0;
    m_pend = 0;
    if (g != 2'b00) begin
      lk = p_lk(gi);
      m_last = gi;
      if (p_rd(gi)) begin
        m_pend = 1; m_pend_port = gi; m_pend_data = ref_mem[p_addr(gi) % 64];
      end else begin
        for (int b = 0; b < 4; b++)
          if ((gi != 0 ? m1_if.byteenable[b] : m0_if.byteenable[b]))
            ref_mem[p_addr(gi) % 64][8*b +: 8] = gi != 0 ? m1_if.writedata[8*b +: 8] : m0_if.writedata[8*b +: 8];
      end
    end
    if (was_locked) begin
      m_remaining--;
      if ((g != 2'b00 && !lk) || m_remaining == 0) begin
        m_locked = 0;
        m_last = m_owner;
      end
    end else if (g != 2'b00 && lk) begin
      m_locked = 1; m_owner = gi; m_remaining = LOCK_MAX;
    end
  endfunction

  function automatic view_t observe();
    view_t v;
    v.wr0  = m0_if.waitrequest;
    v.wr1  = m1_if.waitrequest;
    v.cs   = mem_chipselect;
    v.wr   = mem_chipselect & mem_write;
    v.addr = mem_chipselect ? mem_address : '0;
    v.rdv0 = m0_if.readdatavalid;
    v.rdv1 = m1_if.readdatavalid;
    v.rd0  = m0_if.readdatavalid ? m0_if.readdata : 32'h0;
    v.rd1  = m1_if.readdatavalid ? m1_if.readdata : 32'h0;
    return v;
  endfunction

  task automatic set_req(int p, bit rd, bit wr, int addr, logic [31:0] wd, logic [3:0] be, bit lk);
    if (p == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = ADDR_W'(addr);
      m0_if.writedata = wd; m0_if.byteenable = be; m0_if.lock = lk;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = ADDR_W'(addr);
      m1_if.writedata = wd; m1_if.byteenable = be; m1_if.lock = lk;
    end
  endtask

  task automatic idle_all();
    set_req(0, 0, 0, 0, 32'h0, 4'h0, 0);
    set_req(1, 0, 0, 0, 32'h0, 4'h0, 0);
    freeze = 1'b0;
  endtask

  task automatic next_cycle();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic preload_ram();
    for (int a = 0; a < 64; a++) begin
      logic [31:0] v;
      v = (a == 16) ? 32'hDEADBEEF : (a == 32) ? 32'h0 : $urandom;
      ref_mem[a] = v;
      pre_addr = ADDR_W'(a); pre_data = v; pre_en = 1'b1;
      @(posedge clk);
      #1;
    end
    pre_en = 1'b0;
  endtask

  task automatic apply_reset();
    view_t obs, exp;
    idle_all();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    exp = model_expect(); obs = observe(); n_vec++;
    if (obs !== exp) begin n_err++; $display("[TB] FAIL reset_state: observed %h, expected %h", obs, exp); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    view_t obs, exp;
    idle_all();
    reset_n = 1'b0;
    model_reset();
    preload_ram();
    @(negedge clk);
    exp = model_expect(); obs = observe(); n_vec++;
    if (obs !== exp) begin n_err++; $display("[TB] FAIL reset_idle: observed %h, expected %h", obs, exp); end
    n_vec++;
    if ({m0_if.readdatavalid, m1_if.readdatavalid, mem_chipselect, mem_clken} !== 4'b0001) begin
      n_err++; $display("[TB] FAIL reset_outputs: observed %b, expected 0001", {m0_if.readdatavalid, m1_if.readdatavalid, mem_chipselect, mem_clken});
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    view_t obs, exp;
    set_req(0, 1, 0, 16, 32'h0, 4'hF, 0);
    @(negedge clk);
    exp = model_expect(); obs = observe(); n_vec++;
    if (obs !== exp) begin n_err++; $display("[TB] FAIL single_read_accept: observed %h, expected %h", obs, exp); end
    n_vec++;
    if (m0_if.waitrequest !== 1'b0) begin n_err++; $display("[TB] FAIL single_read_wait: observed %b, expected 0", m0_if.waitrequest); end
    next_cycle();
    idle_all();
    @(negedge clk);
    exp = model_expect(); obs = observe(); n_vec++;
    if (obs !== exp) begin n_err++; $display("[TB] FAIL single_read_return: observed %h, expected %h", obs, exp); end
    n_vec++;
    if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b10 || m0_if.readdata !== 32'hDEADBEEF) begin
      n_err++; $display("[TB] FAIL single_read_data: observed rdv=%b%b data=%h, expected rdv=10 data=deadbeef", m0_if.readdatavalid, m1_if.readdatavalid, m0_if.readdata);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    view_t obs, exp;
    int a0 = 0, a1 = 40;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1, 0, a0, 32'h0, 4'hF, 0);
      set_req(1, 1, 0, a1, 32'h0, 4'hF, 0);
      @(negedge clk);
      exp = model_expect(); obs = observe(); n_vec++;
      if (obs !== exp) begin n_err++; $display("[TB] FAIL contention_cyc%0d: observed %h, expected %h", k, obs, exp); end
      n_vec++;
      if ({m0_if.waitrequest, m1_if.waitrequest} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_err++; $display("[TB] FAIL contention_order_cyc%0d: observed wr=%b%b, expected %s", k, m0_if.waitrequest, m1_if.waitrequest, (k % 2 == 0) ? "01" : "10");
      end
      if (k % 2 == 0) a0++; else a1++;
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    exp = model_expect(); obs = observe(); n_vec++;
    if (obs !== exp) begin n_err++; $display("[TB] FAIL contention_tail: observed %h, expected %h", obs, exp); end
    next_cycle();
  endtask

  task automatic test_byte_write();
    view_t obs, exp;
    set_req(1, 0, 1, 32, 32'h11223344, 4'b0101, 0);
    @(negedge clk);
    exp = model_expect(); obs = observe(); n_vec++;
    if (obs !== exp) begin n_err++; $display("[TB] FAIL byte_write: observed %h, expected %h", obs, exp); end
    next_cycle();
    set_req(1, 1, 0, 32, 32'h0, 4'hF, 0);
    @(negedge clk);
    exp = model_expect(); obs = observe(); n_vec++;
    if (obs !== exp) begin n_err++; $display("[TB] FAIL byte_readback_accept: observed %h, expected %h", obs, exp); end
    next_cycle();
    idle_all();
    @(negedge clk);
    exp = model_expect(); obs = observe(); n_vec++;
    if (obs !== exp) begin n_err++; $display("[TB] FAIL byte_readback_return: observed %h, expected %h", obs, exp); end
    n_vec++;
    if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== 32'h00220044) begin
      n_err++; $display("[TB] FAIL byte_merge: observed rdv=%b data=%h, expected rdv=1 data=00220044", m1_if.readdatavalid, m1_if.readdata);
    end
    next_cycle();
  endtask

  task automatic test_lock();
    view_t obs, exp;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      if (k == 0) set_req(0, 1, 0, 1, 32'h0, 4'hF, 1);
      else if (k == 1) set_req(0, 0, 1, 2, 32'hCAFE0001, 4'hF, 0);
      else set_req(0, 0, 0, 0, 32'h0, 4'h0, 0);
      set_req(1, 1, 0, 50, 32'h0, 4'hF, 0);
      @(negedge clk);
      exp = model_expect(); obs = observe(); n_vec++;
      if (obs !== exp) begin n_err++; $display("[TB] FAIL lock_cyc%0d: observed %h, expected %h", k, obs, exp); end
      n_vec++;
      if ({m0_if.waitrequest, m1_if.waitrequest} !== ((k < 2) ? 2'b01 : 2'b00)) begin
        n_err++; $display("[TB] FAIL lock_hold_cyc%0d: observed wr=%b%b, expected %s", k, m0_if.waitrequest, m1_if.waitrequest, (k < 2) ? "01" : "00");
      end
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    exp = model_expect(); obs = observe(); n_vec++;
    if (obs !== exp) begin n_err++; $display("[TB] FAIL lock_tail: observed %h, expected %h", obs, exp); end
    next_cycle();
  endtask

  task automatic test_lock_timeout();
    view_t obs, exp;
    int granted_at = -1;
    apply_reset();
    for (int k = 0; k < 10 && granted_at < 0; k++) begin
      set_req(0, 1, 0, 3 + k, 32'h0, 4'hF, 1);
      set_req(1, 1, 0, 4, 32'h0, 4'hF, 0);
      @(negedge clk);
      exp = model_expect(); obs = observe(); n_vec++;
      if (obs !== exp) begin n_err++; $display("[TB] FAIL lock_timeout_cyc%0d: observed %h, expected %h", k, obs, exp); end
      if (m1_if.waitrequest === 1'b0) granted_at = k;
      next_cycle();
    end
    n_vec++;
    if (granted_at != 5) begin n_err++; $display("[TB] FAIL lock_timeout_release: observed m1 grant at cycle %0d, expected 5", granted_at); end
    idle_all();
    @(negedge clk);
    exp = model_expect(); obs = observe(); n_vec++;
    if (obs !== exp) begin n_err++; $display("[TB] FAIL lock_timeout_tail: observed %h, expected %h", obs, exp); end
    next_cycle();
  endtask

  task automatic test_freeze();
    view_t obs, exp;
    for (int k = 0; k < 5; k++) begin
      set_req(0, 1, 0, 5, 32'h0, 4'hF, 0);
      set_req(1, 1, 0, 6, 32'h0, 4'hF, 0);
      freeze = (k < 3);
      @(negedge clk);
      exp = model_expect(); obs = observe(); n_vec++;
      if (obs !== exp) begin n_err++; $display("[TB] FAIL freeze_cyc%0d: observed %h, expected %h", k, obs, exp); end
      n_vec++;
      if (k < 3 && {mem_chipselect, m0_if.waitrequest, m1_if.waitrequest} !== 3'b011) begin
        n_err++; $display("[TB] FAIL freeze_block_cyc%0d: observed cs/wr=%b%b%b, expected 011", k, mem_chipselect, m0_if.waitrequest, m1_if.waitrequest);
      end else if (k >= 3 && mem_chipselect !== 1'b1) begin
        n_err++; $display("[TB] FAIL freeze_resume_cyc%0d: observed cs=%b, expected 1", k, mem_chipselect);
      end
      next_cycle();
    end
    idle_all();
  endtask

  task automatic test_reset_inflight();
    view_t obs, exp;
    set_req(0, 1, 0, 16, 32'h0, 4'hF, 0);
    @(negedge clk);
    exp = model_expect(); obs = observe(); n_vec++;
    if (obs !== exp) begin n_err++; $display("[TB] FAIL inflight_accept: observed %h, expected %h", obs, exp); end
    next_cycle();
    idle_all();
    n_vec++;
    if (m0_if.readdatavalid !== 1'b1) begin n_err++; $display("[TB] FAIL inflight_rdv_high: observed %b, expected 1", m0_if.readdatavalid); end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (m0_if.readdatavalid !== 1'b0) begin n_err++; $display("[TB] FAIL inflight_rdv_drop: observed %b, expected 0", m0_if.readdatavalid); end
    model_reset();
    @(negedge clk);
    exp = model_expect(); obs = observe(); n_vec++;
    if (obs !== exp) begin n_err++; $display("[TB] FAIL inflight_after_reset: observed %h, expected %h", obs, exp); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    view_t obs, exp;
    bit          act [2];
    bit          rd  [2];
    int          addr[2];
    logic [31:0] wd  [2];
    logic [3:0]  be  [2];
    bit          lk  [2];
    logic [1:0]  g;
    for (int p = 0; p < 2; p++) act[p] = 0;
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && $urandom_range(0, 9) < 6) begin
          act[p] = 1; rd[p] = $urandom_range(0, 1) != 0; addr[p] = $urandom_range(0, 63);
          wd[p] = $urandom; be[p] = 4'($urandom_range(0, 15)); lk[p] = $urandom_range(0, 3) == 0;
        end
        if (act[p]) set_req(p, rd[p], !rd[p], addr[p], wd[p], be[p], lk[p]);
        else set_req(p, 0, 0, 0, 32'h0, 4'h0, 0);
      end
      freeze = $urandom_range(0, 9) == 0;
      @(negedge clk);
      exp = model_expect(); obs = observe(); n_vec++;
      if (obs !== exp) begin n_err++; $display("[TB] FAIL random_cyc%0d: observed %h, expected %h", k, obs, exp); end
      g = model_grant();
      if (g[0]) act[0] = 0;
      if (g[1]) act[1] = 0;
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    exp = model_expect(); obs = observe(); n_vec++;
    if (obs !== exp) begin n_err++; $display("[TB] FAIL random_tail: observed %h, expected %h", obs, exp); end
    next_cycle();
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_byte_write();
    test_lock();
    test_lock_timeout();
    test_freeze();
    test_reset_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
